screen_write_arbiter: RTL and testbench
=======================================

SCREEN_WRITE_ARBITER -- requirements
Module: screen_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_BYTE, default 8'h20, byte written to every cell by the clear sequence.
REQ-002 SHALL have parameter LAST_COL, default 7'd99, highest column index in a row.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_low  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  requester has a cell write pending.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1 each  requester's write accepted this cycle.
REQ-007 SHALL have ports req0_row/req1_row  input  5; req0_col/req1_col  input  7; req0_byte/req1_byte  input  8  requester cell address and data.
REQ-008 SHALL have port clear_start  input  1  single-cycle request to fill the whole screen with CLEAR_BYTE.
REQ-009 SHALL have port clear_busy  output  1  high while the clear sequence owns the write port.
REQ-010 SHALL have ports write_valid  output  1; write_ready  input  1; write_row  output  5; write_col  output  7; write_byte  output  8  registered shared screen-buffer write port.

Function
REQ-011 SHALL hold one output register (write_valid/row/col/byte); load_en = !write_valid || write_ready.
REQ-012 SHALL, in state ARB, grant one requester per cycle; reqN_ready = load_en && ARB && grant==N; never both readies high.
REQ-013 SHALL arbitrate round-robin: only one valid -> it wins; both valid -> the one not granted last wins; pointer updates only on an accepted transfer.
REQ-014 SHALL present an accepted requester's row/col/byte on write_* with write_valid high the next cycle (1-cycle latency).
REQ-015 SHALL hold write_* stable while write_valid && !write_ready; clear write_valid when write_ready and nothing new loaded.
REQ-016 SHALL support full throughput: one write per cycle when write_ready stays high.
REQ-017 SHALL, on clear_start in ARB, enter CLEAR next cycle; a requester accepted in the same cycle completes normally; clear_start in CLEAR ignored.
REQ-018 SHALL, in CLEAR, drive both readies low and load cells row-major from (0,0) to (31,LAST_COL) with CLEAR_BYTE, one per load_en cycle; col wraps LAST_COL->0 with row+1.
REQ-019 SHALL return to ARB the cycle after cell (31,LAST_COL) is loaded; clear_busy high exactly while in CLEAR.
REQ-020 SHALL not alter arbitration pointer during CLEAR.

Reset
REQ-021 SHALL, on reset_low low (asynchronous, any time incl. mid-clear), force write_valid=0, write_row=0, write_col=0, write_byte=0, state=ARB, clear counters=0, clear_busy=0, pointer=last-granted requester 1.
REQ-022 SHALL drop any in-flight output or partial clear on reset; no cell resumes after release.
REQ-023 SHALL drive req0_ready/req1_ready low while reset_low is low.

Configuration
REQ-024 SHALL compile the clear sequencer only when SCREEN_WRITE_CLEAR_EN is defined.
REQ-025 SHALL, without SCREEN_WRITE_CLEAR_EN, ignore clear_start, tie clear_busy to 0, and remain permanently in ARB.

Verification
REQ-026 Reset then req0_valid only, (3,5,0x41), write_ready=1 -> req0_ready=1 at cycle 0; write_valid=1, row=3, col=5, byte=0x41 at cycle 1.
REQ-027 req0 and req1 both valid for 4 cycles, write_ready=1 -> grants 0,1,0,1; write_byte alternates per requester.
REQ-028 Output loaded, write_ready=0 for 3 cycles -> write_* unchanged, both readies 0; write_ready=1 -> next grant loads same cycle.
REQ-029 clear_start with write_ready=1 (EN defined) -> clear_busy 1 for 3200 cycles, cells (0,0)..(31,99) byte 0x20, (0,99)->(1,0) wrap checked, then ARB.
REQ-030 reset_low pulsed low mid-clear at cell (10,40) -> outputs 0 immediately, clear_busy 0, next req0 write accepted normally.
REQ-031 Without SCREEN_WRITE_CLEAR_EN, clear_start pulse with req1 valid -> clear_busy stays 0, req1 accepted that cycle.

Source files
------------

// File: rtl/screen_write_arbiter.sv
// -----------------------------------------------------------------------------
// screen_write_arbiter
//
// Merges two cell-write requesters onto one registered screen-buffer write
// port. Arbitration is round-robin. An optional clear sequencer can take over
// the port and fill every cell, (0,0) .. (31,LAST_COL) in row-major order,
// with CLEAR_BYTE.
//
// Build option:
//   SCREEN_WRITE_CLEAR_EN  - when defined, the clear sequencer is built. When
//                            it is undefined, clear_start is ignored,
//                            clear_busy is tied low and the block always
//                            arbitrates.
//
// Parameters:
//   CLEAR_BYTE  byte written to every cell by the clear sequence
//   LAST_COL    highest column index in a row
//
// Ports:
//   clk, reset_low            clock, asynchronous active-low reset
//   reqN_valid / reqN_ready   requester N handshake (N = 0, 1)
//   reqN_row/col/byte         requester N cell address and data
//   clear_start               one-cycle request to clear the whole screen
//   clear_busy                high while the clear sequence owns the port
//   write_valid/write_ready   shared write port handshake
//   write_row/col/byte        shared write port address and data (registered)
// -----------------------------------------------------------------------------
module screen_write_arbiter #(
  parameter logic [7:0] CLEAR_BYTE = 8'h20,
  parameter logic [6:0] LAST_COL   = 7'd99
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [4:0] req0_row,
  input  logic [6:0] req0_col,
  input  logic [7:0] req0_byte,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [4:0] req1_row,
  input  logic [6:0] req1_col,
  input  logic [7:0] req1_byte,
  input  logic       clear_start,
  output logic       clear_busy,
  output logic       write_valid,
  input  logic       write_ready,
  output logic [4:0] write_row,
  output logic [6:0] write_col,
  output logic [7:0] write_byte
);

  logic       r_writeValid;
  logic [4:0] r_writeRow;
  logic [6:0] r_writeCol;
  logic [7:0] r_writeByte;
  logic       r_lastGrant;

  logic       w_loadEn;
  logic       w_inClear;
  logic [4:0] w_clearRow;
  logic [6:0] w_clearCol;
  logic       w_grant;
  logic       w_arbOpen;
  logic       w_accept0;
  logic       w_accept1;

  // The output register can take a new cell whenever it is empty or its
  // current cell is leaving this cycle.
  assign w_loadEn = !r_writeValid || write_ready;

`ifdef SCREEN_WRITE_CLEAR_EN
  typedef enum logic {ARB, CLEAR} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [4:0] r_clearRow;
  logic [6:0] r_clearCol;
  logic       w_clearLast;

  assign w_inClear   = (r_state == CLEAR);
  assign w_clearRow  = r_clearRow;
  assign w_clearCol  = r_clearCol;
  assign w_clearLast = (r_clearRow == 5'd31) && (r_clearCol == LAST_COL);

  // State register.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_state <= ARB;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A clear request is only honoured while arbitrating; CLEAR ends once the
  // final cell has gone into the output register.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ARB:     if (clear_start) w_nextState = CLEAR;
      CLEAR:   if (w_loadEn && w_clearLast) w_nextState = ARB;
      default: w_nextState = ARB;
    endcase
  end

  // Clear cursor. It advances row-major once per loaded cell. On the final
  // cell, row 31 + 1 wraps to 0, so the cursor is already back at (0,0) for
  // the next clear.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_clearRow <= '0;
      r_clearCol <= '0;
    end else if (w_inClear && w_loadEn) begin
      if (r_clearCol == LAST_COL) begin
        r_clearCol <= '0;
        r_clearRow <= r_clearRow + 5'd1;
      end else begin
        r_clearCol <= r_clearCol + 7'd1;
      end
    end
  end
`else
  logic [7:0] w_unusedCfg;

  assign w_unusedCfg = {clear_start, LAST_COL};
  assign w_inClear   = 1'b0;
  assign w_clearRow  = '0;
  assign w_clearCol  = '0;
`endif

  assign clear_busy = w_inClear;

  // Round-robin pick. With both requesters pending, the one that was not
  // granted last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_lastGrant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  // reset_low gates the readies directly, so no requester sees an accept
  // while reset is held.
  assign w_arbOpen  = reset_low && w_loadEn && !w_inClear;
  assign w_accept0  = w_arbOpen && req0_valid && !w_grant;
  assign w_accept1  = w_arbOpen && req1_valid && w_grant;
  assign req0_ready = w_accept0;
  assign req1_ready = w_accept1;

  // The pointer moves only on an accepted transfer.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_lastGrant <= 1'b1;
    end else if (w_accept0) begin
      r_lastGrant <= 1'b0;
    end else if (w_accept1) begin
      r_lastGrant <= 1'b1;
    end
  end

  // Output register. It holds while stalled, loads a clear cell or the
  // granted request when it can, and otherwise drains to empty.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_writeValid <= 1'b0;
      r_writeRow   <= '0;
      r_writeCol   <= '0;
      r_writeByte  <= '0;
    end else if (w_loadEn) begin
      if (w_inClear) begin
        r_writeValid <= 1'b1;
        r_writeRow   <= w_clearRow;
        r_writeCol   <= w_clearCol;
        r_writeByte  <= CLEAR_BYTE;
      end else if (w_accept0) begin
        r_writeValid <= 1'b1;
        r_writeRow   <= req0_row;
        r_writeCol   <= req0_col;
        r_writeByte  <= req0_byte;
      end else if (w_accept1) begin
        r_writeValid <= 1'b1;
        r_writeRow   <= req1_row;
        r_writeCol   <= req1_col;
        r_writeByte  <= req1_byte;
      end else begin
        r_writeValid <= 1'b0;
      end
    end
  end

  assign write_valid = r_writeValid;
  assign write_row   = r_writeRow;
  assign write_col   = r_writeCol;
  assign write_byte  = r_writeByte;

endmodule

// File: tb/tb_screen_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_screen_write_arbiter
//
// Self-checking bench for screen_write_arbiter. Each scenario task drives the
// requesters and checks the readies and write port itself. A negedge monitor
// also keeps a queue of expected cells: it pushes each accepted request, or
// the clear task pre-loads the whole clear sequence, and every completed
// write-port transfer is popped from that queue and compared.
// -----------------------------------------------------------------------------
module tb_screen_write_arbiter;

  localparam logic [7:0] CLEAR_BYTE = 8'h20;
  localparam int         LAST_COL   = 99;

  logic       clk = 1'b0;
  logic       reset_low = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [4:0] req0_row = '0;
  logic [6:0] req0_col = '0;
  logic [7:0] req0_byte = '0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [4:0] req1_row = '0;
  logic [6:0] req1_col = '0;
  logic [7:0] req1_byte = '0;
  logic       clear_start = 1'b0;
  logic       clear_busy;
  logic       write_valid;
  logic       write_ready = 1'b0;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_byte;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] row;
    logic [6:0] col;
    logic [7:0] data;
  } cell_t;

  cell_t expQ[$];
  cell_t monExp;

  always #5 clk = ~clk;

  screen_write_arbiter dut (
    .clk         (clk),
    .reset_low   (reset_low),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_row    (req0_row),
    .req0_col    (req0_col),
    .req0_byte   (req0_byte),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_row    (req1_row),
    .req1_col    (req1_col),
    .req1_byte   (req1_byte),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .write_valid (write_valid),
    .write_ready (write_ready),
    .write_row   (write_row),
    .write_col   (write_col),
    .write_byte  (write_byte)
  );

  // Scoreboard monitor. A transfer completing this cycle is compared against
  // the oldest expected cell before anything accepted this cycle is queued.
  always @(negedge clk) begin
    if (reset_low) begin
      if (write_valid && write_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL write_unexpected: got row=%0d col=%0d data=%h, expected no transfer",
                   write_row, write_col, write_byte);
        end else begin
          monExp = expQ.pop_front();
          if ({write_row, write_col, write_byte} !== monExp) begin
            errors++;
            $display("[TB] FAIL write_data: got row=%0d col=%0d data=%h, expected row=%0d col=%0d data=%h",
                     write_row, write_col, write_byte, monExp.row, monExp.col, monExp.data);
          end
        end
      end
      if (req0_ready) expQ.push_back({req0_row, req0_col, req0_byte});
      if (req1_ready) expQ.push_back({req1_row, req1_col, req1_byte});
    end
  end

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus helper for one requester's address and data.
  task automatic applyStimulus(input int idx, input logic valid, input logic [4:0] row,
                               input logic [6:0] col, input logic [7:0] data);
    if (idx == 0) begin
      req0_valid = valid; req0_row = row; req0_col = col; req0_byte = data;
    end else begin
      req1_valid = valid; req1_row = row; req1_col = col; req1_byte = data;
    end
  endtask

  task automatic doReset();
    reset_low = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_low = 1'b1;
    expQ.delete();
    tick();
  endtask

  task automatic test_reset();
    #2 reset_low = 1'b0;
    applyStimulus(0, 1'b1, 5'd1, 7'd1, 8'h11);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", {write_valid, write_row, write_col, write_byte});
    end
    checks++;
    if (clear_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", clear_busy);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b%b, expected 00", req0_ready, req1_ready);
    end
    applyStimulus(0, 1'b0, 5'd0, 7'd0, 8'h00);
    reset_low = 1'b1;
    expQ.delete();
    tick();
  endtask

  task automatic test_single();
    write_ready = 1'b1;
    applyStimulus(0, 1'b1, 5'd3, 7'd5, 8'h41);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b%b, expected 10", req0_ready, req1_ready);
    end
    tick();
    applyStimulus(0, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd3, 7'd5, 8'h41}) begin
      errors++;
      $display("[TB] FAIL single_output: got v=%b row=%0d col=%0d data=%h, expected v=1 row=3 col=5 data=41",
               write_valid, write_row, write_col, write_byte);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] expByte;
    expByte = 8'h00;
    doReset();
    write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 5'(i), 7'(i), 8'hA0 + 8'(i));
      applyStimulus(1, 1'b1, 5'(i + 8), 7'(i + 16), 8'hB0 + 8'(i));
      @(negedge clk);
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: got %b%b, expected %b%b", i, req0_ready, req1_ready,
                 (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        checks++;
        if (write_byte !== expByte) begin
          errors++;
          $display("[TB] FAIL rr_byte%0d: got %h, expected %h", i, write_byte, expByte);
        end
      end
      expByte = (i % 2 == 0) ? (8'hA0 + 8'(i)) : (8'hB0 + 8'(i));
      tick();
    end
    applyStimulus(0, 1'b0, 5'd0, 7'd0, 8'h00);
    applyStimulus(1, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (write_byte !== expByte) begin
      errors++;
      $display("[TB] FAIL rr_byte_last: got %h, expected %h", write_byte, expByte);
    end
    tick();
  endtask

  task automatic test_backpressure();
    write_ready = 1'b1;
    applyStimulus(0, 1'b1, 5'd7, 7'd9, 8'h55);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_first_ready: got %b, expected 1", req0_ready);
    end
    tick();
    write_ready = 1'b0;
    applyStimulus(0, 1'b1, 5'd8, 7'd10, 8'h66);
    applyStimulus(1, 1'b1, 5'd12, 7'd20, 8'h77);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd7, 7'd9, 8'h55}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got v=%b row=%0d col=%0d data=%h, expected v=1 row=7 col=9 data=55",
                 k, write_valid, write_row, write_col, write_byte);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall_ready%0d: got %b%b, expected 00", k, req0_ready, req1_ready);
      end
      tick();
    end
    write_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_resume_grant: got %b%b, expected 01", req0_ready, req1_ready);
    end
    tick();
    applyStimulus(1, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || write_byte !== 8'h77) begin
      errors++;
      $display("[TB] FAIL bp_next: got ready0=%b data=%h, expected ready0=1 data=77", req0_ready, write_byte);
    end
    tick();
    applyStimulus(0, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    checks++;
    if (write_byte !== 8'h66) begin
      errors++;
      $display("[TB] FAIL bp_last_data: got %h, expected 66", write_byte);
    end
    tick();
    @(negedge clk);
    checks++;
    if (write_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain: got %b, expected 0", write_valid);
    end
    tick();
  endtask

`ifdef SCREEN_WRITE_CLEAR_EN
  task automatic pushClearCells();
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c <= LAST_COL; c++) begin
        expQ.push_back({5'(r), 7'(c), CLEAR_BYTE});
      end
    end
  endtask

  task automatic test_clear();
    int         busyCount;
    int         wrapSeen;
    bit         done;
    logic [4:0] prevRow;
    logic [6:0] prevCol;
    busyCount = 0;
    wrapSeen  = 0;
    done      = 1'b0;
    prevRow   = '0;
    prevCol   = '0;
    write_ready = 1'b1;
    clear_start = 1'b1;
    applyStimulus(0, 1'b1, 5'd2, 7'd2, 8'h99);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || clear_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_same_cycle: got ready0=%b busy=%b, expected ready0=1 busy=0", req0_ready, clear_busy);
    end
    #1;
    pushClearCells();
    tick();
    clear_start = 1'b0;
    applyStimulus(0, 1'b1, 5'd4, 7'd4, 8'h98);
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (write_valid && write_row == 5'd1 && write_col == 7'd0) begin
        wrapSeen++;
        checks++;
        if (prevRow !== 5'd0 || prevCol !== 7'(LAST_COL)) begin
          errors++;
          $display("[TB] FAIL clear_wrap: got previous cell row=%0d col=%0d, expected row=0 col=%0d",
                   prevRow, prevCol, LAST_COL);
        end
      end
      if (write_valid) begin
        prevRow = write_row;
        prevCol = write_col;
      end
      if (clear_busy) begin
        busyCount++;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL clear_ready_low: got %b%b, expected 00", req0_ready, req1_ready);
        end
        if (c == 50) clear_start = 1'b1;
        if (c == 51) clear_start = 1'b0;
      end else begin
        done = 1'b1;
        checks++;
        if (req0_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL clear_back_to_arb: got ready0=%b, expected 1", req0_ready);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL clear_timeout: busy still %b after 4000 cycles, expected 0", clear_busy);
    end
    checks++;
    if (busyCount != 3200) begin
      errors++;
      $display("[TB] FAIL clear_busy_len: got %0d, expected 3200", busyCount);
    end
    checks++;
    if (wrapSeen != 1) begin
      errors++;
      $display("[TB] FAIL clear_wrap_seen: got %0d, expected 1", wrapSeen);
    end
    tick();
    applyStimulus(0, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd4, 7'd4, 8'h98}) begin
      errors++;
      $display("[TB] FAIL clear_after_req: got v=%b row=%0d col=%0d data=%h, expected v=1 row=4 col=4 data=98",
               write_valid, write_row, write_col, write_byte);
    end
    tick();
  endtask

  task automatic test_clear_reset();
    bit found;
    found = 1'b0;
    write_ready = 1'b1;
    clear_start = 1'b1;
    @(negedge clk);
    #1;
    pushClearCells();
    tick();
    clear_start = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (write_valid && write_row == 5'd10 && write_col == 7'd40) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL clrst_reach: cell (10,40) seen=%b, expected 1", found);
    end
    reset_low = 1'b0;
    applyStimulus(0, 1'b1, 5'd5, 7'd6, 8'h3C);
    #1;
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== 21'd0 || clear_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clrst_outputs: got out=%h busy=%b, expected out=0 busy=0",
               {write_valid, write_row, write_col, write_byte}, clear_busy);
    end
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clrst_ready_in_reset: got %b, expected 0", req0_ready);
    end
    expQ.delete();
    @(posedge clk);
    #1;
    reset_low = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || clear_busy !== 1'b0 || write_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clrst_release: got ready0=%b busy=%b valid=%b, expected 1 0 0",
               req0_ready, clear_busy, write_valid);
    end
    tick();
    applyStimulus(0, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd5, 7'd6, 8'h3C} || clear_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clrst_req_out: got v=%b row=%0d col=%0d data=%h busy=%b, expected v=1 row=5 col=6 data=3c busy=0",
               write_valid, write_row, write_col, write_byte, clear_busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (write_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clrst_no_resume: got valid=%b, expected 0", write_valid);
    end
    tick();
  endtask
`else
  task automatic test_no_clear();
    write_ready = 1'b1;
    clear_start = 1'b1;
    applyStimulus(1, 1'b1, 5'd9, 7'd33, 8'hC3);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || clear_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noclr_accept: got ready1=%b busy=%b, expected 1 0", req1_ready, clear_busy);
    end
    tick();
    clear_start = 1'b0;
    applyStimulus(1, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    checks++;
    if ({write_valid, write_row, write_col, write_byte} !== {1'b1, 5'd9, 7'd33, 8'hC3} || clear_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noclr_output: got v=%b row=%0d col=%0d data=%h busy=%b, expected v=1 row=9 col=33 data=c3 busy=0",
               write_valid, write_row, write_col, write_byte, clear_busy);
    end
    tick();
    applyStimulus(0, 1'b1, 5'd1, 7'd2, 8'h0F);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || clear_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noclr_still_arb: got ready0=%b busy=%b, expected 1 0", req0_ready, clear_busy);
    end
    tick();
    applyStimulus(0, 1'b0, 5'd0, 7'd0, 8'h00);
    @(negedge clk);
    tick();
  endtask
`endif

  initial begin
    $display("[TB] starting screen_write_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
`ifdef SCREEN_WRITE_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_no_clear();
`endif
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drained: got %0d pending cells, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
